ram_fifo_rd: RTL and testbench
==============================

# ram_fifo_rd

Fabric-side read controller for the RAM block operating in FIFO mode (FMODE=1). Pops words from the RAM read port by driving its read enable, absorbs the one-cycle read latency in a two-entry prefetch buffer, and presents a valid/ready stream to downstream fabric logic at full throughput. It also sequences FIFO flushes so that no stale word leaks to the consumer.

## Interface
- DATA_WIDTH, 32, stream width; legal values 32, 16, 8. This value selects ram_rmode.
- clk  in  1  read-side clock; the same net drives RAM RCLK.
- rst_n  in  1  asynchronous, active-low reset.
- ram_empty  in  1  RAM FFLAGS empty bit (1 = no word available); it accounts for every ram_ren up to the previous cycle.
- ram_rdata  in  32  RAM RDATA; valid in the cycle after ram_ren.
- ram_ren  out  1  RAM REN; combinational output.
- ram_rmode  out  2  RAM RMODE constant: 2'b00 for 32, 2'b01 for 16, 2'b10 for 8.
- ram_fflush  out  1  RAM FFLUSH pulse; registered.
- flush  in  1  synchronous flush request from the fabric.
- m_data  out  DATA_WIDTH  stream data, taken from ram_rdata[DATA_WIDTH-1:0].
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- level  out  2  number of words held in the buffer (0..2).
- pop_count  out  16  count of accepted stream beats; wraps modulo 2^16.

## Operation
- Storage is a two-entry FIFO buffer, with a head entry and a tail entry. The inflight flag is set when a read was issued in the previous cycle.
- A pop is m_valid && m_ready.
- Issue rule: ram_ren = (state==RUN) && !ram_empty && (level + inflight - pop) < 2. ram_ren therefore depends combinationally on m_ready.
- Capture: when inflight=1 in state RUN, ram_rdata is written into the buffer at the end of that cycle. This write happens together with any pop in the same cycle.
- m_valid = (level != 0). m_data always shows the head entry. Once m_valid is high, head data is held stable until it is popped.
- Ordering is strict FIFO. No word is ever dropped or duplicated outside of a flush.
- State machine with states RUN, FLUSH, SETTLE:
  - RUN → FLUSH when flush=1.
  - FLUSH lasts one cycle: ram_fflush=1, the buffer is cleared, inflight is discarded, ram_ren=0.
  - FLUSH → SETTLE. SETTLE lasts two cycles with ram_ren=0, letting the RAM flags settle.
  - SETTLE → RUN.
  - A flush received during FLUSH or SETTLE restarts the FLUSH state.
- Flush wins over a same-cycle pop: that beat is not counted and the word is discarded.
- pop_count increments on each pop and wraps from 0xFFFF to 0x0000. Flush does not clear it.
- DATA_WIDTH outside {8,16,32}: elaboration error.

## Timing
- Reset values (rst_n low, asynchronous): state=RUN, level=0, inflight=0, m_valid=0, m_data=0, ram_fflush=0, pop_count=0. ram_ren is therefore 0.
- First-word latency: ram_empty falls in cycle t → ram_ren=1 in cycle t → data captured at the end of t+1 → m_valid=1 in cycle t+2.
- Steady state with m_ready held at 1 and the RAM non-empty: one beat per cycle, with level alternating at 1 and one read in flight.
- Backpressure with m_ready=0: at most 2 reads are outstanding or held, after which ram_ren drops. No overflow is possible.
- ram_empty rising while a read is in flight: that in-flight word is still captured. No further reads are issued.
- Flush: ram_fflush is high for exactly 1 cycle, in the cycle after flush is sampled. m_valid is 0 from that same cycle. ram_ren is first possible 3 cycles after the FLUSH state.
- Mid-operation reset clears all state immediately. Any data returning after reset is ignored, because inflight=0.

## Test plan
- Reset, then ram_empty=0 with words 0x11,0x22,0x33 and m_ready=1 → ram_ren goes high in cycle 0. m_data shows 0x11,0x22,0x33 in cycles 2,3,4. pop_count=3.
- Backpressure: m_ready=0 with 5 words available → ram_ren asserts exactly twice, then level=2. Raising m_ready then drains all 5 words in order with no gaps after the first.
- Empty boundary: a single word 0xA5, with ram_empty rising the cycle after its ram_ren → exactly one beat 0xA5 is delivered, then m_valid=0 and ram_ren stays 0.
- Flush with level=2, a read in flight, and a simultaneous pop → ram_fflush pulses for 1 cycle and m_valid=0. The popped beat is not counted. ram_ren stays 0 for 3 cycles. The next word delivered is the first word written after the flush.
- pop_count wrap: preload via 65535 beats, then one more beat → pop_count=0x0000.
- DATA_WIDTH=8 with ram_rdata=0xDEADBEEF → m_data=0xEF and ram_rmode=2'b10. Asserting rst_n low mid-stream drops m_valid, level and ram_ren to 0 immediately.

Source files
------------

// File: rtl/ram_fifo_rd_if.sv
// Stream handshake between the RAM FIFO read controller and its fabric consumer.
interface ram_fifo_rd_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/ram_fifo_rd.sv
// Fabric-side read controller for the RAM in FIFO mode: issues REN, absorbs the
// one-cycle read latency in a two-entry buffer, and sequences FIFO flushes.
module ram_fifo_rd #(
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ram_empty,
  input  logic [31:0]   ram_rdata,
  output logic          ram_ren,
  output logic [1:0]    ram_rmode,
  output logic          ram_fflush,
  input  logic          flush,
  ram_fifo_rd_if.master m,
  output logic [1:0]    level,
  output logic [15:0]   pop_count
);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 16 && DATA_WIDTH != 8) begin : g_bad_width
    $error("ram_fifo_rd: DATA_WIDTH must be 8, 16 or 32");
  end

  function automatic logic [1:0] rmode_of(input int w);
    case (w)
      16:      return 2'b01;
      8:       return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  typedef enum logic [1:0] {RUN, FLUSH, SETTLE} state_t;

  state_t                state, state_nxt;
  logic                  settle_cnt, settle_nxt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head, tail;
  logic [DATA_WIDTH-1:0] rdata_w;
  logic                  rdata_unused;
  logic                  pop, wr;
  logic [2:0]            occ;

  assign ram_rmode    = rmode_of(DATA_WIDTH);
  assign rdata_w      = ram_rdata[DATA_WIDTH-1:0];
  assign rdata_unused = ^ram_rdata;

  assign m.m_valid = (level != 2'd0);
  assign m.m_data  = head;
  assign pop       = m.m_valid && m.m_ready;
  assign wr        = inflight && (state == RUN);

  // Occupancy once this cycle settles; reads stop when it would exceed the buffer.
  assign occ     = {1'b0, level} + {2'b00, inflight} - {2'b00, pop};
  assign ram_ren = rst_n && (state == RUN) && !ram_empty && (occ < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      settle_cnt <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      RUN:    state_nxt = RUN;
      FLUSH: begin
        state_nxt  = SETTLE;
        settle_nxt = 1'b0;
      end
      SETTLE: begin
        if (settle_cnt) state_nxt = RUN;
        else            settle_nxt = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
    // A new request always (re)starts the flush sequence.
    if (flush) state_nxt = FLUSH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_fflush <= 1'b0;
      inflight   <= 1'b0;
      pop_count  <= 16'd0;
    end else begin
      ram_fflush <= flush;
      inflight   <= ram_ren && !flush;
      if (pop && !flush) pop_count <= pop_count + 16'd1;
    end
  end

  // Two-entry buffer; a flush discards contents and any word returning next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      level <= 2'd0;
    end else begin
      case ({wr, pop})
        2'b11: begin
          if (level == 2'd2) begin
            head <= tail;
            tail <= rdata_w;
          end else begin
            head <= rdata_w;
          end
        end
        2'b10: begin
          if (level == 2'd0) head <= rdata_w;
          else               tail <= rdata_w;
          level <= level + 2'd1;
        end
        2'b01: begin
          if (level == 2'd2) head <= tail;
          level <= level - 2'd1;
        end
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_fifo_rd.sv
// Directed bench for ram_fifo_rd: RAM FIFO model, expected-word scoreboard and
// a negedge monitor comparing every accepted beat.
module tb_ram_fifo_rd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_empty = 1'b1;
  logic [31:0] ram_rdata = 32'd0;
  logic        ram_ren;
  logic [1:0]  ram_rmode;
  logic        ram_fflush;
  logic        flush;
  logic [1:0]  level;
  logic [15:0] pop_count;

  logic        rst8_n;
  logic        empty8;
  logic [31:0] rdata8;
  logic        ren8;
  logic [1:0]  rmode8;
  logic        fflush8;
  logic        flush8;
  logic [1:0]  level8;
  logic [15:0] pc8;

  ram_fifo_rd_if #(.DATA_WIDTH(32)) s_if ();
  ram_fifo_rd_if #(.DATA_WIDTH(8))  s8_if ();

  ram_fifo_rd #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ram_empty(ram_empty), .ram_rdata(ram_rdata),
    .ram_ren(ram_ren), .ram_rmode(ram_rmode), .ram_fflush(ram_fflush),
    .flush(flush), .m(s_if), .level(level), .pop_count(pop_count)
  );

  ram_fifo_rd #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .ram_empty(empty8), .ram_rdata(rdata8),
    .ram_ren(ren8), .ram_rmode(rmode8), .ram_fflush(fflush8),
    .flush(flush8), .m(s8_if), .level(level8), .pop_count(pc8)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] wr_q[$];
  logic [31:0] ram_q[$];
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM FIFO model: words written by the bench appear one edge later; REN pops
  // with one cycle of read latency; FFLUSH empties it.
  always @(posedge clk) begin
    if (ram_fflush) ram_q.delete();
    else if (ram_ren) ram_rdata <= ram_q.pop_front();
    while (wr_q.size() != 0) ram_q.push_back(wr_q.pop_front());
    ram_empty <= (ram_q.size() == 0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        exp_q.delete();
      end else if (s_if.m_valid && s_if.m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", s_if.m_data, 32'hFFFF_FFFF);
        else                   chk("beat_data", s_if.m_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    wr_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ren_cnt;
    int val_cnt;
    rst_n = 1'b0; rst8_n = 1'b0; flush = 1'b0; flush8 = 1'b0;
    s_if.m_ready = 1'b0; s8_if.m_ready = 1'b0;
    empty8 = 1'b1; rdata8 = 32'hDEAD_BEEF;
    repeat (2) tick();

    chk("rst_valid",  s_if.m_valid, 0);
    chk("rst_level",  level, 0);
    chk("rst_ren",    ram_ren, 0);
    chk("rst_fflush", ram_fflush, 0);
    chk("rst_popcnt", pop_count, 0);
    chk("rst_data",   s_if.m_data, 0);
    chk("rmode32",    ram_rmode, 2'b00);

    rst_n = 1'b1;
    rst8_n = 1'b1;
    tick();

    // Three words, full throughput
    s_if.m_ready = 1'b1;
    push(32'h11); push(32'h22); push(32'h33);
    tick();
    chk("t1_ren_c0", ram_ren, 1);
    tick(); tick();
    chk("t1_valid_c2", s_if.m_valid, 1);
    chk("t1_data_c2", s_if.m_data, 32'h11);
    tick(); chk("t1_data_c3", s_if.m_data, 32'h22);
    tick(); chk("t1_data_c4", s_if.m_data, 32'h33);
    tick();
    chk("t1_valid_c5", s_if.m_valid, 0);
    chk("t1_popcnt", pop_count, 3);

    // Backpressure: two reads then stall
    s_if.m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(32'hA0 + i);
    ren_cnt = 0;
    repeat (8) begin
      tick();
      ren_cnt += int'(ram_ren);
    end
    chk("t2_ren_count", ren_cnt, 2);
    chk("t2_level", level, 2);
    s_if.m_ready = 1'b1;
    val_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      val_cnt += int'(s_if.m_valid);
      tick();
    end
    chk("t2_no_gaps", val_cnt, 5);
    chk("t2_valid_end", s_if.m_valid, 0);
    chk("t2_popcnt", pop_count, 8);

    // Empty boundary: one word only
    push(32'hA5);
    ren_cnt = 0;
    val_cnt = 0;
    repeat (6) begin
      tick();
      ren_cnt += int'(ram_ren);
      val_cnt += int'(s_if.m_valid);
    end
    chk("t3_ren_count", ren_cnt, 1);
    chk("t3_beats", val_cnt, 1);
    chk("t3_valid_end", s_if.m_valid, 0);
    chk("t3_popcnt", pop_count, 9);

    // Flush with full buffer, concurrent pop and concurrent read
    s_if.m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(32'hB0 + i);
    repeat (5) tick();
    chk("t4_level_full", level, 2);
    flush = 1'b1;
    s_if.m_ready = 1'b1;
    #1;
    chk("t4_ren_at_flush", ram_ren, 1);
    tick();
    flush = 1'b0;
    chk("t4_fflush", ram_fflush, 1);
    chk("t4_valid", s_if.m_valid, 0);
    chk("t4_ren_flush", ram_ren, 0);
    chk("t4_popcnt", pop_count, 9);
    push(32'hC1);
    tick();
    chk("t4_fflush_pulse", ram_fflush, 0);
    chk("t4_ren_settle1", ram_ren, 0);
    tick();
    chk("t4_ren_settle2", ram_ren, 0);
    tick();
    chk("t4_ren_run", ram_ren, 1);
    wait_drain(20);
    chk("t4_popcnt_after", pop_count, 10);

    // pop_count wrap
    for (int i = 0; i < 65525; i++) push(32'h1000_0000 + i);
    wait_drain(70000);
    chk("t5_popcnt_max", pop_count, 16'hFFFF);
    push(32'h5A5A_5A5A);
    wait_drain(20);
    chk("t5_popcnt_wrap", pop_count, 16'h0000);

    // 8-bit instance: lane select, mode, asynchronous reset
    empty8 = 1'b0;
    repeat (5) tick();
    chk("t6_rmode8", rmode8, 2'b10);
    chk("t6_level8", level8, 2);
    chk("t6_valid8", s8_if.m_valid, 1);
    chk("t6_data8", s8_if.m_data, 8'hEF);
    rst8_n = 1'b0;
    #1;
    chk("t6_rst_valid", s8_if.m_valid, 0);
    chk("t6_rst_level", level8, 0);
    chk("t6_rst_ren", ren8, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
